// File: rtl/abs_encoder_poll_scheduler_pkg.sv
// Shared types and constants for the RS485 absolute-encoder poll scheduler.
package abs_poll_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SEND   = 3'd2,
    TXWAIT = 3'd3,
    LISTEN = 3'd4,
    GAP    = 3'd5
  } state_e;

  localparam logic [15:0] ERR_MAX = 16'hffff;

  // Whole MHz times microseconds gives a cycle count without 64-bit intermediates.
  function automatic logic [31:0] US_DIV(input int unsigned clk_hz, input int unsigned us);
    return 32'((clk_hz / 32'd1000000) * us);
  endfunction

endpackage

// File: rtl/abs_encoder_poll_scheduler_if.sv
// UART transmitter and frame-parser handshake seen by the poll scheduler.
interface abs_encoder_poll_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_enable;
  logic       frame_valid;
  logic       frame_error;
  logic       rx_accept;

  modport master (
    output tx_data, tx_start, tx_enable, rx_accept,
    input  tx_busy, frame_valid, frame_error
  );

  modport slave (
    input  tx_data, tx_start, tx_enable, rx_accept,
    output tx_busy, frame_valid, frame_error
  );
endinterface

// File: rtl/abs_encoder_poll_scheduler_rr.sv
// Round-robin pick: first set mask bit strictly after idx_i, wrapping back to idx_i itself.
module rr_slot_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] idx_i,
  output logic [IW-1:0] next_o,
  output logic          none_o
);

  logic [IW-1:0] pos_s;

  // Scan from farthest to nearest so the closest set bit after idx_i wins.
  always_comb begin
    next_o = idx_i;
    none_o = 1'b1;
    pos_s  = idx_i;
    for (int k = N; k >= 1; k--) begin
      pos_s = IW'((int'(idx_i) + k) % N);
      if (mask_i[pos_s]) begin
        next_o = pos_s;
        none_o = 1'b0;
      end else begin
        none_o = none_o;
      end
    end
  end

endmodule

// File: rtl/abs_encoder_poll_scheduler.sv
// Round-robin poller for absolute encoders sharing one half-duplex RS485 bus.
module abs_encoder_poll_scheduler
  import abs_poll_pkg::*;
#(
  parameter int          ClkFrequency = 32400000,
  parameter int          SLOTS        = 4,
  parameter logic [7:0]  CMD_BASE     = 8'h7d,
  parameter int          TIMEOUT_US   = 1000,
  parameter int          GAP_US       = 10,
  parameter int          MAX_RETRY    = 2,
  localparam int         SW           = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [SLOTS-1:0]              slot_mask,
  output logic [SW-1:0]                 cur_slot,
  output logic [SLOTS-1:0]              fault,
  output logic [15:0]                   err_count,
  output logic                          busy,
  abs_encoder_poll_scheduler_if.master  bus
);

  localparam logic [31:0] TO_CYC  = US_DIV(ClkFrequency, TIMEOUT_US);
  localparam logic [31:0] GAP_CYC = US_DIV(ClkFrequency, GAP_US);

  state_e             state_q, state_d;
  logic [SW-1:0]      cur_slot_q, cur_slot_d;
  logic [7:0]         retry_q, retry_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_enable_q, tx_enable_d;
  logic               rx_accept_q, rx_accept_d;
  logic [SLOTS-1:0]   fault_q, fault_d;
  logic [15:0]        err_q, err_d;
  logic               resend_q, resend_d;
  logic               first_q, first_d;
  logic [SW-1:0]      pick_idx_s;
  logic               pick_none_s;

  rr_slot_pick #(.N(SLOTS), .IW(SW)) u_pick (
    .mask_i (slot_mask),
    .idx_i  (cur_slot_q),
    .next_o (pick_idx_s),
    .none_o (pick_none_s)
  );

  // State and output registers; reset leaves the line driven idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_slot_q  <= SW'(SLOTS - 1);
      retry_q     <= 8'd0;
      cnt_q       <= 32'd0;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      tx_enable_q <= 1'b1;
      rx_accept_q <= 1'b0;
      fault_q     <= '0;
      err_q       <= 16'd0;
      resend_q    <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_slot_q  <= cur_slot_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      tx_enable_q <= tx_enable_d;
      rx_accept_q <= rx_accept_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
      resend_q    <= resend_d;
      first_q     <= first_d;
    end
  end

  // Next-state and output logic for the poll sequence.
  always_comb begin
    state_d     = state_q;
    cur_slot_d  = cur_slot_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    tx_enable_d = tx_enable_q;
    rx_accept_d = 1'b0;
    fault_d     = fault_q;
    err_d       = err_q;
    resend_d    = resend_q;
    first_d     = first_q;
    case (state_q)
      IDLE: begin
        tx_enable_d = 1'b1;
        if (enable && (|slot_mask)) state_d = SELECT;
        else                        state_d = IDLE;
      end
      SELECT: begin
        if (pick_none_s) begin
          state_d = IDLE;
        end else begin
          cur_slot_d = pick_idx_s;
          retry_d    = 8'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d  = CMD_BASE + 8'(cur_slot_q);
          tx_start_d = 1'b1;
          first_d    = 1'b1;
          state_d    = TXWAIT;
        end else begin
          state_d = SEND;
        end
      end
      TXWAIT: begin
        // uart_tx raises busy a cycle after the strobe, so the first cycle is not trusted.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!bus.tx_busy) begin
          tx_enable_d = 1'b0;
          cnt_d       = TO_CYC;
          state_d     = LISTEN;
        end else begin
          state_d = TXWAIT;
        end
      end
      LISTEN: begin
        cnt_d = (cnt_q != 32'd0) ? (cnt_q - 32'd1) : 32'd0;
        if (bus.frame_valid) begin
          rx_accept_d         = 1'b1;
          fault_d[cur_slot_q] = 1'b0;
          resend_d            = 1'b0;
          cnt_d               = GAP_CYC;
          state_d             = GAP;
        end else if (bus.frame_error || (cnt_q == 32'd0)) begin
          err_d = (err_q != ERR_MAX) ? (err_q + 16'd1) : err_q;
          if (retry_q < 8'(MAX_RETRY)) begin
            retry_d  = retry_q + 8'd1;
            resend_d = 1'b1;
          end else begin
            fault_d[cur_slot_q] = 1'b1;
            resend_d            = 1'b0;
          end
          cnt_d   = GAP_CYC;
          state_d = GAP;
        end else begin
          state_d = LISTEN;
        end
      end
      GAP: begin
        if (cnt_q <= 32'd1) begin
          tx_enable_d = 1'b1;
          resend_d    = 1'b0;
          if (resend_q)                    state_d = SEND;
          else if (enable && (|slot_mask)) state_d = SELECT;
          else                             state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.rx_accept = rx_accept_q;
  assign cur_slot      = cur_slot_q;
  assign fault         = fault_q;
  assign err_count     = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/abs_encoder_poll_scheduler.md
Name: abs_encoder_poll_scheduler

Overview:
- Sequences one shared half-duplex RS485 bus between up to SLOTS absolute encoders.
- Round-robin polls each enabled slot by sending a one-byte request through an external uart_tx.
- Owns the bus direction (tx_enable), enforces the response timeout and inter-request gap, and retries failed polls.
- Reports which slot answered so a downstream frame parser / angle tracker can latch data per axis.

Parameters:
- ClkFrequency, 32400000, clk frequency in Hz.
- SLOTS, 4, number of encoder slots (1..8).
- CMD_BASE, 8'h7d, request byte for slot 0; slot i sends CMD_BASE + i (8-bit wrap).
- TIMEOUT_US, 1000, response window after the request byte leaves the line.
- GAP_US, 10, bus turnaround and idle gap before the next request.
- MAX_RETRY, 2, retries per slot before it is marked faulted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  polling enable.
- slot_mask  in  SLOTS  per-slot poll enable.
- tx_data  out  8  byte to uart_tx.
- tx_start  out  1  one-cycle start strobe to uart_tx.
- tx_busy  in  1  uart_tx busy.
- tx_enable  out  1  RS485 driver enable; 1 = drive.
- frame_valid  in  1  one-cycle pulse from the parser: good frame received.
- frame_error  in  1  one-cycle pulse from the parser: checksum or length error.
- cur_slot  out  clog2(SLOTS)  slot currently owning the bus.
- rx_accept  out  1  one-cycle pulse: frame_valid accepted for cur_slot.
- fault  out  SLOTS  sticky per-slot fault flag; cleared by that slot's next good frame.
- err_count  out  16  saturating total count of failed attempts (timeouts and errors).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - tx_enable = 1.
  - tx_start = 0, tx_data = 0.
  - cur_slot = SLOTS-1, so the first poll goes to slot 0.
  - rx_accept = 0, fault = 0, err_count = 0, retry = 0.
- Derived counts: TO_CYC = ClkFrequency/1000000*TIMEOUT_US; GAP_CYC = ClkFrequency/1000000*GAP_US. Both are computed at elaboration and held in a 32-bit counter.
- IDLE:
  - If enable is high and (slot_mask & all-ones) != 0, go to SELECT.
  - Otherwise stay in IDLE with tx_enable = 1.
- SELECT (1 cycle):
  - cur_slot = first set mask bit strictly after cur_slot, wrapping round-robin.
  - If only the current slot is set, it is selected again.
  - retry = 0. Go to SEND.
- SEND:
  - Wait for tx_busy == 0.
  - Then tx_data = CMD_BASE + cur_slot and tx_start = 1 for exactly one cycle. Go to TXWAIT.
- TXWAIT:
  - Ignore tx_busy in the first cycle, to cover uart_tx start latency.
  - Then wait for tx_busy == 0. When it falls: tx_enable = 0, counter = TO_CYC, go to LISTEN.
- LISTEN:
  - Counter decrements every cycle.
  - If frame_valid: rx_accept = 1 for one cycle, clear fault[cur_slot], go to GAP.
  - Else if frame_error or counter == 0: err_count += 1 (saturates at 16'hffff).
    - If retry < MAX_RETRY: retry += 1, next = resend of the same slot.
    - Otherwise: set fault[cur_slot], next = SELECT.
    - In both cases go through GAP first.
  - If frame_valid and frame_error arrive in the same cycle, frame_valid wins.
- GAP:
  - tx_enable stays 0 for GAP_CYC cycles. Then tx_enable = 1.
  - Go to SEND if a resend is pending. Otherwise go to SELECT if enable && slot_mask != 0, else IDLE.
- frame_valid or frame_error outside LISTEN: ignored, no counters touched.
- enable falling mid-transaction: the current attempt completes, including retries, then the block enters IDLE after GAP.
- slot_mask changing mid-transaction:
  - Affects only the next SELECT.
  - A faulted slot whose mask bit is cleared keeps its fault flag.
- rst_n asserted at any time: immediate return to reset values. tx_enable = 1, so the line is driven idle.

Decomposition:
- Package abs_poll_pkg holds:
  - state enum IDLE/SELECT/SEND/TXWAIT/LISTEN/GAP, 3 bits.
  - US_DIV helper constant function.
  - ERR_MAX = 16'hffff.
- Sub-module rr_slot_pick: combinational round-robin "next set bit after index" over SLOTS bits.
  - Outputs the index and a none-set flag.
  - Reused by other bus schedulers.

Test Plan (bench params: ClkFrequency = 1000000, SLOTS = 4, TIMEOUT_US = 20, GAP_US = 2, MAX_RETRY = 2; uart_tx model holds busy for 10 cycles):
- Reset, enable = 1, mask = 4'b1111, parser answers every request with frame_valid 5 cycles into LISTEN -> tx_data sequence 7d, 7e, 7f, 80, 7d; rx_accept once per slot; tx_enable low from busy fall through 2 gap cycles.
- mask = 4'b0101, all answered -> requests alternate 7d, 7f; cur_slot alternates 0, 2.
- Slot 1 never answers, mask = 4'b0010 -> three requests of 7e spaced 20 + 2 cycles; then fault = 4'b0010, err_count = 3; the next cycle is a new request 7e with fault still set; a good frame then clears fault.
- frame_error on attempt 1, frame_valid on attempt 2 -> err_count = 1, fault = 0, rx_accept pulses once.
- frame_valid and frame_error in the same LISTEN cycle -> accepted, err_count unchanged. frame_valid injected during GAP -> no rx_accept.
- enable dropped during LISTEN -> the transaction finishes, then IDLE with busy = 0 and tx_enable = 1. rst_n pulsed mid-TXWAIT -> all outputs at reset values immediately, asynchronously.
